// File: rtl/bus_alu_mdr_pkg.sv
// bus_alu_mdr_pkg: shared constants for the single-bus datapath slice.
//   - 5-bit ALU opcode values
//   - bit positions of the one-hot bus-drive strobes in bus_src
package bus_alu_mdr_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BRZR = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;

  // bus_src strobe positions; R0..R15 occupy bits 0..15.
  localparam int unsigned SRC_R0     = 0;
  localparam int unsigned SRC_HI     = 16;
  localparam int unsigned SRC_LO     = 17;
  localparam int unsigned SRC_ZHI    = 18;
  localparam int unsigned SRC_ZLO    = 19;
  localparam int unsigned SRC_PC     = 20;
  localparam int unsigned SRC_MDR    = 21;
  localparam int unsigned SRC_INPORT = 22;
  localparam int unsigned SRC_C      = 23;

endpackage

// File: rtl/bus_alu_mdr_if.sv
// bus_alu_mdr_if: datapath signals shared between the control/datapath
// (master) and the ALU/encoder/MDR block (slave).
//   MDR:     mdr_enable, read, mdatain -> mdr_out
//   bus:     bus_in (operand B / MDR write data), bus_src -> bus_sel
//   ALU:     y_in, opcode, inc_pc -> c_hi, c_lo
interface bus_alu_mdr_if;
  logic        mdr_enable;
  logic        read;
  logic [31:0] bus_in;
  logic [31:0] mdatain;
  logic [31:0] mdr_out;
  logic [31:0] bus_src;
  logic [4:0]  bus_sel;
  logic [31:0] y_in;
  logic [4:0]  opcode;
  logic        inc_pc;
  logic [31:0] c_hi;
  logic [31:0] c_lo;

  modport master (
    output mdr_enable, read, bus_in, mdatain, bus_src, y_in, opcode, inc_pc,
    input  mdr_out, bus_sel, c_hi, c_lo
  );

  modport slave (
    input  mdr_enable, read, bus_in, mdatain, bus_src, y_in, opcode, inc_pc,
    output mdr_out, bus_sel, c_hi, c_lo
  );
endinterface

// File: rtl/bus_alu_mdr_alu_core.sv
// alu_core: combinational 32-bit ALU producing a 64-bit {hi,lo} result.
//   a, b    : operands (Y register, bus)
//   opcode  : operation select
//   inc_pc  : forces b + 1 regardless of opcode
//   result  : {hi, lo}; hi is zero except for mul and div
module alu_core
  import bus_alu_mdr_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  opcode,
  input  logic        inc_pc,
  output logic [63:0] result
);

  logic [4:0]         sh;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [63:0] prod;
  logic               div_zero;
  logic               div_ovf;
  logic signed [31:0] div_b;
  logic signed [31:0] quot;
  logic signed [31:0] rem;

  assign sh = b[4:0];
  assign sa = $signed(a);
  assign sb = $signed(b);

  assign prod = sa * sb;

  // Special divide cases are substituted with a harmless divisor so the
  // divider never sees /0 or the overflowing MIN/-1 pair.
  assign div_zero = (b == '0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == '1);
  assign div_b    = (div_zero || div_ovf) ? 32'sd1 : sb;
  assign quot     = sa / div_b;
  assign rem      = sa % div_b;

  always_comb begin
    result = {32'h0, b};
    if (inc_pc) begin
      result = {32'h0, b + 32'd1};
    end else begin
      unique case (opcode)
        OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI, OP_BRZR, OP_JR, OP_JAL:
                          result = {32'h0, a + b};
        OP_SUB:           result = {32'h0, a - b};
        OP_AND, OP_ANDI:  result = {32'h0, a & b};
        OP_OR, OP_ORI:    result = {32'h0, a | b};
        OP_SHR:           result = {32'h0, a >> sh};
        OP_SHRA:          result = {32'h0, 32'(sa >>> sh)};
        OP_SHL:           result = {32'h0, a << sh};
        // A shift by 32 yields zero, so sh = 0 rotates to a unchanged.
        OP_ROR:           result = {32'h0, (a >> sh) | (a << (6'd32 - {1'b0, sh}))};
        OP_ROL:           result = {32'h0, (a << sh) | (a >> (6'd32 - {1'b0, sh}))};
        OP_MUL:           result = prod;
        OP_DIV: begin
          if (div_zero)      result = {a, 32'hFFFF_FFFF};
          else if (div_ovf)  result = {32'h0, 32'h8000_0000};
          else               result = {rem, quot};
        end
        OP_NEG:           result = {32'h0, 32'h0 - b};
        OP_NOT:           result = {32'h0, ~b};
        default:          result = {32'h0, b};
      endcase
    end
  end

endmodule

// File: rtl/bus_alu_mdr.sv
// bus_alu_mdr: bus-source encoder, ALU and Memory Data Register.
//   clk, clr : clock and synchronous active-high reset (MDR only)
//   bus      : slave side of bus_alu_mdr_if
//     bus_sel  = index of lowest set bit of bus_src (0 when none)
//     c_hi/lo  = combinational ALU result from y_in and bus_in
//     mdr_out  = MDR, loaded from mdatain (read=1) or bus_in on mdr_enable
module bus_alu_mdr
  import bus_alu_mdr_pkg::*;
(
  input logic         clk,
  input logic         clr,
  bus_alu_mdr_if.slave bus
);

  logic [31:0] mdr;
  logic [4:0]  sel;
  logic        found;
  logic [63:0] alu_res;

  always_ff @(posedge clk) begin
    if (clr)                 mdr <= '0;
    else if (bus.mdr_enable) mdr <= bus.read ? bus.mdatain : bus.bus_in;
  end

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (bus.bus_src[i] && !found) begin
        sel   = 5'(i);
        found = 1'b1;
      end
    end
  end

  alu_core u_alu (
    .a      (bus.y_in),
    .b      (bus.bus_in),
    .opcode (bus.opcode),
    .inc_pc (bus.inc_pc),
    .result (alu_res)
  );

  assign bus.mdr_out = mdr;
  assign bus.bus_sel = sel;
  assign bus.c_hi    = alu_res[63:32];
  assign bus.c_lo    = alu_res[31:0];

endmodule

// File: tb/tb_bus_alu_mdr.sv
module tb_bus_alu_mdr;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  bus_alu_mdr_if bus ();

  bus_alu_mdr dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  typedef struct {
    int          id;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdr;
    logic [4:0]  sel;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int          item_id = 0;
  logic [31:0] mdr_model = '0;

  // Reference ALU from the arithmetic definitions, using 64-bit integers.
  function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op, input logic inc);
    longint      sa, sb, q, r, p, prod;
    int unsigned s;
    logic [31:0] lo, hi, t;
    sa = $signed(a);
    sb = $signed(b);
    s  = int'(b[4:0]);
    p  = longint'(1) << s;
    hi = '0;
    lo = b;
    if (inc) lo = b + 32'd1;
    else begin
      case (op)
        5'd0, 5'd1, 5'd2, 5'd3, 5'd12, 5'd19, 5'd20, 5'd21: lo = 32'(sa + sb);
        5'd4:  lo = 32'(sa - sb);
        5'd5, 5'd13: lo = a & b;
        5'd6, 5'd14: lo = a | b;
        5'd7:  lo = 32'(longint'({32'h0, a}) / p);
        5'd8:  lo = (sa >= 0) ? 32'(sa / p) : 32'(-((-sa + p - 1) / p));
        5'd9:  lo = 32'(longint'({32'h0, a}) * p);
        5'd10: begin t = a; repeat (s) t = {t[0], t[31:1]}; lo = t; end
        5'd11: begin t = a; repeat (s) t = {t[30:0], t[31]}; lo = t; end
        5'd15: begin prod = sa * sb; {hi, lo} = prod; end
        5'd16: begin
          if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) lo = 32'h8000_0000;
          else begin
            q = sa / sb;
            r = sa - q * sb;
            lo = 32'(q);
            hi = 32'(r);
          end
        end
        5'd17: lo = 32'(-sb);
        5'd18: lo = ~b;
        default: lo = b;
      endcase
    end
    return {hi, lo};
  endfunction

  function automatic logic [4:0] ref_sel(input logic [31:0] src);
    logic [4:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) if (src[i]) r = 5'(i);
    return r;
  endfunction

  task automatic issue(input logic c, input logic en, input logic rd,
                       input logic [31:0] bi, input logic [31:0] md,
                       input logic [31:0] src, input logic [31:0] y,
                       input logic [4:0] op, input logic inc);
    exp_t e;
    @(negedge clk);
    clr            = c;
    bus.mdr_enable = en;
    bus.read       = rd;
    bus.bus_in     = bi;
    bus.mdatain    = md;
    bus.bus_src    = src;
    bus.y_in       = y;
    bus.opcode     = op;
    bus.inc_pc     = inc;
    if (c) mdr_model = '0;
    else if (en) mdr_model = rd ? md : bi;
    e.id = item_id;
    {e.hi, e.lo} = ref_alu(y, bi, op, inc);
    e.mdr = mdr_model;
    e.sel = ref_sel(src);
    sbq.push_back(e);
    item_id++;
  endtask

  task automatic alu(input logic [4:0] op, input logic [31:0] y, input logic [31:0] bi);
    issue(1'b0, 1'b0, 1'b0, bi, 32'h0, 32'h0, y, op, 1'b0);
  endtask

  // Monitor: outputs are sampled just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        total++;
        if (bus.c_lo !== e.lo) begin
          bad++;
          $display("FAIL c_lo item=%0d actual=%h expected=%h", e.id, bus.c_lo, e.lo);
        end
        total++;
        if (bus.c_hi !== e.hi) begin
          bad++;
          $display("FAIL c_hi item=%0d actual=%h expected=%h", e.id, bus.c_hi, e.hi);
        end
        total++;
        if (bus.bus_sel !== e.sel) begin
          bad++;
          $display("FAIL bus_sel item=%0d actual=%0d expected=%0d", e.id, bus.bus_sel, e.sel);
        end
        total++;
        if (bus.mdr_out !== e.mdr) begin
          bad++;
          $display("FAIL mdr_out item=%0d actual=%h expected=%h", e.id, bus.mdr_out, e.mdr);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, b, src;
    logic [4:0]  op;
    clr = 1'b1;
    bus.mdr_enable = 1'b0;
    bus.read = 1'b0;
    bus.bus_in = '0;
    bus.mdatain = '0;
    bus.bus_src = '0;
    bus.y_in = '0;
    bus.opcode = '0;
    bus.inc_pc = 1'b0;

    // reset
    issue(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    // encoder
    issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0010_0000, 32'h0, 5'd24, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0020_0004, 32'h0, 5'd24, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd24, 1'b0);
    // MDR load / hold / clear priority
    issue(1'b0, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd24, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 32'h5, 32'h0, 32'h0, 32'h0, 5'd24, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 5'd24, 1'b0);
    issue(1'b1, 1'b1, 1'b1, 32'h5, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd24, 1'b0);
    // arithmetic / logic
    alu(5'd3, 32'd7, 32'hFFFF_FFFD);
    alu(5'd4, 32'd0, 32'd1);
    alu(5'd5, 32'h0000_F0F0, 32'h0000_0FF0);
    issue(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1);
    // shifts / rotates
    alu(5'd8, 32'h8000_0000, 32'd4);
    alu(5'd7, 32'h8000_0000, 32'd4);
    alu(5'd11, 32'h8000_0001, 32'd1);
    alu(5'd11, 32'h8000_0001, 32'd33);
    alu(5'd10, 32'h8000_0001, 32'd0);
    alu(5'd10, 32'h8000_0001, 32'd31);
    alu(5'd9, 32'h0000_0003, 32'd31);
    // mul / div
    alu(5'd15, 32'hFFFF_FFFE, 32'd3);
    alu(5'd15, 32'h7FFF_FFFF, 32'd2);
    alu(5'd16, 32'hFFFF_FFF9, 32'd2);
    alu(5'd16, 32'h1234_5678, 32'd0);
    alu(5'd16, 32'h8000_0000, 32'hFFFF_FFFF);
    alu(5'd16, 32'd7, 32'hFFFF_FFFE);
    // unary / default
    alu(5'd17, 32'h0, 32'd5);
    alu(5'd18, 32'h0, 32'd0);
    alu(5'd24, 32'hAAAA_AAAA, 32'd9);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      a  = $urandom;
      b  = $urandom;
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) b = 32'($urandom_range(0, 2)) - 32'd1;
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 70));
      case ($urandom_range(0, 2))
        0: src = 32'h0;
        1: src = 32'h1 << $urandom_range(0, 31);
        default: src = $urandom;
      endcase
      issue($urandom_range(0, 15) == 0, 1'($urandom), 1'($urandom), b, $urandom,
            src, a, op, $urandom_range(0, 9) == 0);
    end

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
